// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory req/ack bus with timeout, pipeline stall,
// branch resolution and the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem2reg,
    input  logic        zero,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        wb_reg_write,
    output logic        wb_mem2reg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg,
    output logic        err_misalign,
    output logic        err_bus_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q;
    logic               mem_op, aligned;
    logic               issue, misalign, acked, expired;

    assign mem_op  = mem_read | mem_write;
    assign aligned = (alu_result[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mem_op && aligned) state_d = S_ACCESS;
            S_ACCESS: if (dmem_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Ack takes priority over timeout expiry in the same cycle.
    always_comb begin
        issue    = 1'b0;
        misalign = 1'b0;
        acked    = 1'b0;
        expired  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue    = mem_op & aligned;
                misalign = mem_op & ~aligned;
                stall    = mem_op & aligned;
            end
            S_ACCESS: begin
                stall   = 1'b1;
                acked   = dmem_ack;
                expired = ~dmem_ack & (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue)
            cnt_d = '0;
        else if ((state_q == S_ACCESS) && !acked && !expired)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            cnt_q           <= '0;
            rdata_q         <= '0;
            err_misalign    <= 1'b0;
            err_bus_timeout <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            err_misalign <= misalign;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write;
                dmem_addr  <= alu_result;
                dmem_wdata <= store_data;
            end else if (acked || expired) begin
                dmem_req <= 1'b0;
            end
            // Stores leave the load buffer untouched.
            if (acked && !dmem_we)
                rdata_q <= dmem_rdata;
            else if (expired)
                rdata_q <= '0;
            if (expired)
                err_bus_timeout <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalled, misaligned ops never write back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_write  <= 1'b0;
            wb_mem2reg    <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= '0;
        end else if (stall) begin
            wb_reg_write <= 1'b0;
            wb_mem2reg   <= 1'b0;
        end else begin
            wb_reg_write  <= reg_write & (aligned | ~mem_op);
            wb_mem2reg    <= mem2reg;
            wb_alu_result <= alu_result;
            wb_write_reg  <= write_reg;
            wb_read_data  <= (state_q == S_DONE) ? rdata_q : 32'h0;
        end
    end

    assign pc_src        = branch & zero & ~stall;
    assign branch_target = pc_target;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: single-cycle vector table plus
// hand-written load/store/timeout/reset sequences against a TIMEOUT=4 instance.
module tb_mem_stage_ctrl;

    localparam int unsigned TB_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, mem_read, mem_write, reg_write, mem2reg, zero;
    logic [31:0] pc_target, alu_result, store_data;
    logic [4:0]  write_reg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        pc_src, stall;
    logic [31:0] branch_target;
    logic        wb_reg_write, wb_mem2reg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic        err_misalign, err_bus_timeout;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] tb_buf = 32'h0;
    logic        tb_tmo = 1'b0;

    mem_stage_ctrl #(.TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem2reg(mem2reg), .zero(zero),
        .pc_target(pc_target), .alu_result(alu_result), .store_data(store_data),
        .write_reg(write_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
        .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_write_reg(wb_write_reg),
        .err_misalign(err_misalign), .err_bus_timeout(err_bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br, zr, mr, mw, rw, m2r;
        logic [31:0] alu, tgt;
        logic [4:0]  wr;
        logic        e_pc, e_rw, e_m2r, e_mis;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        branch = 0; zero = 0; mem_read = 0; mem_write = 0; reg_write = 0;
        mem2reg = 0; pc_target = 0; alu_result = 0; store_data = 0; write_reg = 0;
    endtask

    // One aligned memory instruction from IDLE through DONE; ack_at = 0 means never.
    task automatic mem_seq(input string nm, input bit is_load, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int ack_at, input logic [4:0] wr, input bit rw);
        int  last;
        int  n_stall;
        bit  tmo;
        tmo  = (ack_at == 0) || (ack_at > int'(TB_TO));
        last = tmo ? int'(TB_TO) : ack_at;
        n_stall = 0;
        branch = 1; zero = 1; pc_target = 32'h0000_0800;
        mem_read = is_load; mem_write = !is_load; reg_write = rw; mem2reg = is_load;
        alu_result = addr; store_data = sdata; write_reg = wr; dmem_ack = 0;
        #1;
        chk({nm, " idle stall"}, 32'(stall), 32'd1);
        chk({nm, " idle pc_src"}, 32'(pc_src), 32'd0);
        chk({nm, " idle req"}, 32'(dmem_req), 32'd0);
        n_stall += int'(stall);
        step();
        for (int i = 1; i <= last; i++) begin
            chk({nm, " acc req"}, 32'(dmem_req), 32'd1);
            chk({nm, " acc addr"}, dmem_addr, addr);
            chk({nm, " acc we"}, 32'(dmem_we), 32'(!is_load));
            chk({nm, " acc wdata"}, dmem_wdata, sdata);
            chk({nm, " acc bubble"}, 32'(wb_reg_write), 32'd0);
            chk({nm, " acc pc_src"}, 32'(pc_src), 32'd0);
            n_stall += int'(stall);
            dmem_ack   = (i == ack_at);
            dmem_rdata = (i == ack_at) ? rdata : 32'hBAD0_0000 + 32'(i);
            step();
            dmem_ack   = 0;
            dmem_rdata = 32'h0;
        end
        chk({nm, " stall cycles"}, 32'(n_stall), 32'(1 + last));
        chk({nm, " done stall"}, 32'(stall), 32'd0);
        chk({nm, " done req"}, 32'(dmem_req), 32'd0);
        chk({nm, " done pc_src"}, 32'(pc_src), 32'd1);
        if (tmo) begin
            tb_buf = 32'h0;
            tb_tmo = 1'b1;
        end else if (is_load) begin
            tb_buf = rdata;
        end
        step();
        drive_nop();
        chk({nm, " wb_reg_write"}, 32'(wb_reg_write), 32'(rw));
        chk({nm, " wb_mem2reg"}, 32'(wb_mem2reg), 32'(is_load));
        chk({nm, " wb_read_data"}, wb_read_data, tb_buf);
        chk({nm, " wb_alu_result"}, wb_alu_result, addr);
        chk({nm, " wb_write_reg"}, 32'(wb_write_reg), 32'(wr));
        chk({nm, " err_bus_timeout"}, 32'(err_bus_timeout), 32'(tb_tmo));
        #1;
        chk({nm, " post stall"}, 32'(stall), 32'd0);
        step();
        chk({nm, " no reissue"}, 32'(dmem_req), 32'd0);
        chk({nm, " post rdata"}, wb_read_data, 32'h0);
        chk({nm, " post wb_rw"}, 32'(wb_reg_write), 32'd0);
    endtask

    initial begin
        //          br zr mr mw rw m2r alu            tgt            wr     pc rw m2r mis
        vecs[0] = '{0, 0, 0, 0, 1, 0, 32'h0000_0042, 32'h0,         5'd5,  0, 1, 0,  0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0400, 5'd0,  1, 0, 0,  0};
        vecs[2] = '{1, 0, 0, 0, 0, 0, 32'h0000_0014, 32'h0000_0400, 5'd0,  0, 0, 0,  0};
        vecs[3] = '{0, 0, 1, 0, 1, 1, 32'h0000_0102, 32'h0,         5'd7,  0, 0, 1,  1};
        vecs[4] = '{0, 0, 0, 1, 0, 0, 32'h0000_0203, 32'h0,         5'd9,  0, 0, 0,  1};
        vecs[5] = '{0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,         5'd31, 0, 1, 0,  0};
        vecs[6] = '{1, 1, 0, 0, 1, 0, 32'h1234_5678, 32'h8000_0000, 5'd12, 1, 1, 0,  0};

        rst = 1; dmem_ack = 0; dmem_rdata = 0;
        drive_nop();
        #1;
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'h0);
        chk("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst wb_read_data", wb_read_data, 32'h0);
        chk("rst err_bus_timeout", 32'(err_bus_timeout), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        step();
        rst = 0;
        step();

        for (int v = 0; v < 7; v++) begin
            branch = vecs[v].br; zero = vecs[v].zr;
            mem_read = vecs[v].mr; mem_write = vecs[v].mw;
            reg_write = vecs[v].rw; mem2reg = vecs[v].m2r;
            alu_result = vecs[v].alu; pc_target = vecs[v].tgt;
            write_reg = vecs[v].wr; store_data = 32'h5555_AAAA;
            #1;
            chk($sformatf("v%0d pc_src", v), 32'(pc_src), 32'(vecs[v].e_pc));
            chk($sformatf("v%0d branch_target", v), branch_target, vecs[v].tgt);
            chk($sformatf("v%0d stall", v), 32'(stall), 32'd0);
            step();
            chk($sformatf("v%0d wb_reg_write", v), 32'(wb_reg_write), 32'(vecs[v].e_rw));
            chk($sformatf("v%0d wb_mem2reg", v), 32'(wb_mem2reg), 32'(vecs[v].e_m2r));
            chk($sformatf("v%0d wb_alu_result", v), wb_alu_result, vecs[v].alu);
            chk($sformatf("v%0d wb_write_reg", v), 32'(wb_write_reg), 32'(vecs[v].wr));
            chk($sformatf("v%0d err_misalign", v), 32'(err_misalign), 32'(vecs[v].e_mis));
            chk($sformatf("v%0d dmem_req", v), 32'(dmem_req), 32'd0);
            chk($sformatf("v%0d wb_read_data", v), wb_read_data, 32'h0);
        end
        drive_nop();
        step();

        mem_seq("load",     1'b1, 32'h0000_0100, 32'h0000_0055, 32'hDEAD_BEEF, 3, 5'd3, 1'b1);
        mem_seq("store",    1'b0, 32'h0000_0204, 32'h0000_1234, 32'h7777_7777, 1, 5'd4, 1'b0);
        mem_seq("ack_last", 1'b1, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 4, 5'd6, 1'b1);
        mem_seq("timeout",  1'b1, 32'h0000_0308, 32'h0,         32'h0,         0, 5'd8, 1'b1);
        step();
        chk("timeout sticky", 32'(err_bus_timeout), 32'd1);

        // Reset during the second ACCESS cycle abandons the access.
        mem_read = 1; reg_write = 1; mem2reg = 1; alu_result = 32'h0000_0400; write_reg = 5'd2;
        step();
        step();
        chk("rstmid pre req", 32'(dmem_req), 32'd1);
        #2;
        drive_nop();
        rst = 1;
        #1;
        chk("rstmid req", 32'(dmem_req), 32'd0);
        chk("rstmid addr", dmem_addr, 32'h0);
        chk("rstmid stall", 32'(stall), 32'd0);
        chk("rstmid wb_alu", wb_alu_result, 32'h0);
        chk("rstmid wb_rdata", wb_read_data, 32'h0);
        chk("rstmid err_tmo", 32'(err_bus_timeout), 32'd0);
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst req", 32'(dmem_req), 32'd0);
            chk("postrst stall", 32'(stall), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
